dkver1_peak_reader: RTL and testbench



---
 rtl/dkver1_peak_reader_if.sv | 9 +
 rtl/dkver1_peak_reader.sv | 157 +++++++++++++++
 tb/tb_dkver1_peak_reader.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dkver1_peak_reader_if.sv
// Host word stream of dkver1_peak_reader: one 32-bit word moves per rd_valid & rd_ready.
interface dkver1_peak_reader_if;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/dkver1_peak_reader.sv
// Peak event capture FIFO and three-word serializer for the host readout path.
// Optional timestamp field and counter: define DKVER1_PEAK_READER_TS_EN.
module dkver1_peak_reader #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 clr,
    input  logic [13:0]          peakout1,
    input  logic [13:0]          peakout2,
    input  logic [13:0]          peakout3,
    input  logic [13:0]          peakout4,
    input  logic                 peakvalid,
    dkver1_peak_reader_if.master rd,
    output logic [CW-1:0]        fifo_count,
    output logic [15:0]          overflow_cnt
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
`ifdef DKVER1_PEAK_READER_TS_EN
    localparam int unsigned EW = 84;
`else
    localparam int unsigned EW = 68;
`endif

    typedef enum logic [1:0] {StIdle, StW0, StW1, StW2} state_e;

    state_e        state_q;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] hold_q;
    logic [EW-1:0] new_entry;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [11:0]   seq_q;
    logic [15:0]   ovf_q;
    logic [31:0]   rd_data_q;
    logic          rd_valid_q;
    logic          capture, fifo_empty, fifo_full, pop, push;

    // Entry layout (MSB first): seq, [ts], peak4, peak3, peak2, peak1.
`ifdef DKVER1_PEAK_READER_TS_EN
    logic [15:0] ts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else if (clr) begin
            ts_q <= '0;
        end else if (ce) begin
            ts_q <= ts_q + 16'd1;
        end
    end

    assign new_entry = {seq_q, ts_q, peakout4, peakout3, peakout2, peakout1};

    function automatic logic [31:0] word0(input logic [EW-1:0] e);
        return {4'hA, e[EW-1 -: 12], e[71:56]};
    endfunction
`else
    assign new_entry = {seq_q, peakout4, peakout3, peakout2, peakout1};

    function automatic logic [31:0] word0(input logic [EW-1:0] e);
        return {4'hA, e[EW-1 -: 12], 16'h0000};
    endfunction
`endif

    function automatic logic [31:0] word1(input logic [EW-1:0] e);
        return {2'b00, e[27:14], 2'b00, e[13:0]};
    endfunction

    function automatic logic [31:0] word2(input logic [EW-1:0] e);
        return {2'b00, e[55:42], 2'b00, e[41:28]};
    endfunction

    assign capture    = ce & peakvalid & ~clr;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign pop  = ~clr & ~fifo_empty & ((state_q == StIdle) | ((state_q == StW2) & rd.rd_ready));
    assign push = capture & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            ovf_q    <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            ovf_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            // Dropped events still consume a sequence number.
            if (capture) begin
                seq_q <= seq_q + 12'd1;
                if (!push && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            hold_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (clr) begin
            state_q    <= StIdle;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (pop) begin
            hold_q     <= mem[rd_ptr_q];
            rd_data_q  <= word0(mem[rd_ptr_q]);
            rd_valid_q <= 1'b1;
            state_q    <= StW0;
        end else if (rd.rd_ready) begin
            unique case (state_q)
                StW0: begin
                    rd_data_q <= word1(hold_q);
                    state_q   <= StW1;
                end
                StW1: begin
                    rd_data_q <= word2(hold_q);
                    state_q   <= StW2;
                end
                StW2: begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                    state_q    <= StIdle;
                end
                default: ;
            endcase
        end
    end

    assign rd.rd_data   = rd_data_q;
    assign rd.rd_valid  = rd_valid_q;
    assign fifo_count   = count_q;
    assign overflow_cnt = ovf_q;
endmodule

// File: tb/tb_dkver1_peak_reader.sv
// Self-checking bench for dkver1_peak_reader against a queue-based event/word model.
module tb_dkver1_peak_reader;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef DKVER1_PEAK_READER_TS_EN
    localparam logic [31:0] HDR_SINGLE = 32'hA000_0005;
    localparam logic [31:0] HDR_CE     = 32'hA003_0003;
    localparam int          WRAP_GAP   = 16;
`else
    localparam logic [31:0] HDR_SINGLE = 32'hA000_0000;
    localparam logic [31:0] HDR_CE     = 32'hA003_0000;
    localparam int          WRAP_GAP   = 4;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic          clr = 1'b0;
    logic          peakvalid = 1'b0;
    logic [13:0]   p1 = '0, p2 = '0, p3 = '0, p4 = '0;
    logic [CW-1:0] fifo_count;
    logic [15:0]   overflow_cnt;
    int            n_cmp = 0;
    int            n_fail = 0;

    dkver1_peak_reader_if rd_if ();

    dkver1_peak_reader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ce           (ce),
        .clr          (clr),
        .peakout1     (p1),
        .peakout2     (p2),
        .peakout3     (p3),
        .peakout4     (p4),
        .peakvalid    (peakvalid),
        .rd           (rd_if.master),
        .fifo_count   (fifo_count),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    // Model: each stored event is kept as its three output words {w0, w1, w2}.
    logic [95:0] m_fifo[$];
    logic [95:0] m_ser = '0;
    bit          m_active = 0;
    int          m_idx = 0;
    int          m_seq = 0, m_ts = 0, m_ovf = 0;
    logic [31:0] got[$];
    logic [31:0] exp_w[$];

    function automatic logic [95:0] make_event(input int s, input int t,
                                               input logic [13:0] a, input logic [13:0] b,
                                               input logic [13:0] c, input logic [13:0] d);
        logic [15:0] tf;
`ifdef DKVER1_PEAK_READER_TS_EN
        tf = t[15:0];
`else
        tf = 16'h0000;
`endif
        return {4'hA, s[11:0], tf, 2'b00, b, 2'b00, a, 2'b00, d, 2'b00, c};
    endfunction

    function automatic logic [31:0] m_word();
        return m_ser[95 - 32 * m_idx -: 32];
    endfunction

    initial begin
        bit do_pop;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_fifo.delete();
                m_active = 0; m_idx = 0; m_seq = 0; m_ts = 0; m_ovf = 0;
            end else begin
                if (rd_if.rd_valid && rd_if.rd_ready) got.push_back(rd_if.rd_data);
                if (clr) begin
                    m_fifo.delete();
                    m_active = 0; m_idx = 0; m_seq = 0; m_ts = 0; m_ovf = 0;
                end else begin
                    do_pop = (m_fifo.size() > 0) && (!m_active || (m_idx == 2 && rd_if.rd_ready));
                    if (m_active && rd_if.rd_ready) begin
                        if (m_idx == 2) m_active = 0;
                        else m_idx++;
                    end
                    if (do_pop) begin
                        m_ser = m_fifo.pop_front();
                        m_active = 1;
                        m_idx = 0;
                        for (int k = 0; k < 3; k++) exp_w.push_back(m_ser[95 - 32 * k -: 32]);
                    end
                    if (ce && peakvalid) begin
                        if (m_fifo.size() < DEPTH) m_fifo.push_back(make_event(m_seq, m_ts, p1, p2, p3, p4));
                        else if (m_ovf < 65535) m_ovf++;
                        m_seq = (m_seq + 1) % 4096;
                    end
                    if (ce) m_ts = (m_ts + 1) % 65536;
                end
            end
        end
    end

    task automatic do_clr();
        clr = 1'b1;
        peakvalid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        got.delete();
        exp_w.delete();
    endtask

    task automatic wait_drain(input int budget, output bit timed_out);
        rd_if.rd_ready = 1'b1;
        peakvalid = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!rd_if.rd_valid && fifo_count == '0 && !m_active && m_fifo.size() == 0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic rand_peaks();
        p1 = 14'($urandom); p2 = 14'($urandom); p3 = 14'($urandom); p4 = 14'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b0; clr = 1'b0; peakvalid = 1'b0; rd_if.rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_rd: valid=%b data=%h expected 0/0", rd_if.rd_valid, rd_if.rd_data);
        end
        n_cmp++;
        if (fifo_count !== '0 || overflow_cnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_cnt: count=%0d ovf=%0d expected 0/0", fifo_count, overflow_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rd_if.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: valid=%b expected 0", rd_if.rd_valid);
        end
    endtask

    task automatic test_single();
        bit to;
        do_clr();
        rd_if.rd_ready = 1'b1;
        ce = 1'b1;
        repeat (5) @(negedge clk);
        p1 = 14'd1; p2 = 14'd2; p3 = 14'd3; p4 = 14'd4;
        peakvalid = 1'b1;
        @(negedge clk);
        peakvalid = 1'b0;
        n_cmp++;
        if (fifo_count !== CW'(1) || rd_if.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_capture: count=%0d valid=%b expected 1/0", fifo_count, rd_if.rd_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== HDR_SINGLE) begin
            n_fail++; $display("FAIL single_w0: valid=%b data=%h expected 1/%h", rd_if.rd_valid, rd_if.rd_data, HDR_SINGLE);
        end
        @(negedge clk);
        n_cmp++;
        if (rd_if.rd_data !== 32'h0002_0001) begin
            n_fail++; $display("FAIL single_w1: data=%h expected 00020001", rd_if.rd_data);
        end
        @(negedge clk);
        n_cmp++;
        if (rd_if.rd_data !== 32'h0004_0003) begin
            n_fail++; $display("FAIL single_w2: data=%h expected 00040003", rd_if.rd_data);
        end
        @(negedge clk);
        n_cmp++;
        if (rd_if.rd_valid !== 1'b0 || fifo_count !== '0) begin
            n_fail++; $display("FAIL single_end: valid=%b count=%0d expected 0/0", rd_if.rd_valid, fifo_count);
        end
        wait_drain(20, to);
    endtask

    task automatic test_backpressure();
        bit to;
        int bad;
        do_clr();
        rd_if.rd_ready = 1'b0;
        ce = 1'b1;
        p1 = 14'd1; p2 = 14'd2; p3 = 14'd3; p4 = 14'd4;
        peakvalid = 1'b1;
        @(negedge clk);
        peakvalid = 1'b0;
        @(negedge clk);
        rd_if.rd_ready = 1'b1;
        @(negedge clk);
        rd_if.rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 32'h0002_0001) begin
                n_fail++; $display("FAIL bp_hold[%0d]: valid=%b data=%h expected 1/00020001", i, rd_if.rd_valid, rd_if.rd_data);
            end
        end
        wait_drain(20, to);
        n_cmp++;
        if (to) begin
            n_fail++; $display("FAIL bp_drain: timed out, expected drain");
        end
        bad = 0;
        if (got.size() != 3) bad = 99;
        else if (got[1] !== 32'h0002_0001 || got[2] !== 32'h0004_0003 || got[0][27:16] !== 12'h000) bad = 1;
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_words: %0d words, bad=%0d expected 3 words 0", got.size(), bad);
        end
    endtask

    task automatic test_overflow();
        bit to;
        int bad;
        do_clr();
        rd_if.rd_ready = 1'b0;
        ce = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_peaks();
            peakvalid = 1'b1;
            @(negedge clk);
        end
        peakvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fifo_count !== CW'(16) || overflow_cnt !== 16'd3) begin
            n_fail++; $display("FAIL ovf_counts: count=%0d ovf=%0d expected 16/3", fifo_count, overflow_cnt);
        end
        n_cmp++;
        if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data[27:16] !== 12'h000) begin
            n_fail++; $display("FAIL ovf_held: valid=%b data=%h expected 1/seq 0", rd_if.rd_valid, rd_if.rd_data);
        end
        wait_drain(200, to);
        bad = 0;
        if (to || got.size() != 51) bad = 999;
        else for (int k = 0; k < 17; k++) if (got[3 * k][27:16] !== 12'(k)) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL ovf_seq: %0d words, bad headers=%0d expected 51 words 0", got.size(), bad);
        end
        bad = 0;
        if (exp_w.size() != got.size()) bad = 999;
        else foreach (got[k]) if (got[k] !== exp_w[k]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL ovf_stream: mismatched words=%0d expected 0", bad);
        end
    endtask

    task automatic test_clr();
        bit to;
        do_clr();
        rd_if.rd_ready = 1'b0;
        ce = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_peaks();
            peakvalid = 1'b1;
            @(negedge clk);
        end
        peakvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fifo_count !== CW'(5)) begin
            n_fail++; $display("FAIL clr_pre: count=%0d expected 5", fifo_count);
        end
        clr = 1'b1;
        peakvalid = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        peakvalid = 1'b0;
        got.delete();
        exp_w.delete();
        n_cmp++;
        if (rd_if.rd_valid !== 1'b0 || fifo_count !== '0 || overflow_cnt !== 16'h0) begin
            n_fail++; $display("FAIL clr_after: valid=%b count=%0d ovf=%0d expected 0/0/0", rd_if.rd_valid, fifo_count, overflow_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if (fifo_count !== '0 || rd_if.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL clr_discard: count=%0d valid=%b expected 0/0", fifo_count, rd_if.rd_valid);
        end
        rand_peaks();
        peakvalid = 1'b1;
        @(negedge clk);
        wait_drain(20, to);
        n_cmp++;
        if (to || got.size() != 3 || got[0][27:16] !== 12'h000) begin
            n_fail++; $display("FAIL clr_seq: words=%0d hdr=%h expected 3 words seq 0", got.size(), got.size() > 0 ? got[0] : 32'h0);
        end
    endtask

    task automatic test_ce_low();
        bit to;
        int bad;
        do_clr();
        rd_if.rd_ready = 1'b1;
        ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_peaks();
            peakvalid = 1'b1;
            @(negedge clk);
        end
        ce = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rand_peaks();
            peakvalid = 1'($urandom);
            @(negedge clk);
        end
        peakvalid = 1'b0;
        n_cmp++;
        if (fifo_count !== '0 || rd_if.rd_valid !== 1'b0 || got.size() != 9) begin
            n_fail++; $display("FAIL ce_drain: count=%0d valid=%b words=%0d expected 0/0/9", fifo_count, rd_if.rd_valid, got.size());
        end
        ce = 1'b1;
        p1 = 14'd7; p2 = 14'd8; p3 = 14'd9; p4 = 14'd10;
        peakvalid = 1'b1;
        @(negedge clk);
        wait_drain(20, to);
        n_cmp++;
        if (to || got.size() != 12 || got[9] !== HDR_CE) begin
            n_fail++; $display("FAIL ce_frozen: words=%0d hdr=%h expected 12 words hdr %h", got.size(), got.size() > 9 ? got[9] : 32'h0, HDR_CE);
        end
        bad = 0;
        if (exp_w.size() != got.size()) bad = 999;
        else foreach (got[k]) if (got[k] !== exp_w[k]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL ce_stream: mismatched words=%0d expected 0", bad);
        end
    endtask

    task automatic test_wrap();
        bit to;
        int bad;
        int dt;
        do_clr();
        rd_if.rd_ready = 1'b1;
        ce = 1'b1;
        for (int i = 0; i < 4097; i++) begin
            rand_peaks();
            peakvalid = 1'b1;
            @(negedge clk);
            peakvalid = 1'b0;
            repeat (WRAP_GAP - 1) @(negedge clk);
        end
        wait_drain(50, to);
        n_cmp++;
        if (to || got.size() != 3 * 4097) begin
            n_fail++; $display("FAIL wrap_count: words=%0d expected %0d", got.size(), 3 * 4097);
        end else begin
            n_cmp++;
            if (got[3 * 4095][27:16] !== 12'hFFF || got[3 * 4096][27:16] !== 12'h000) begin
                n_fail++; $display("FAIL wrap_seq: hdrs %h %h expected seq FFF then 000", got[3 * 4095], got[3 * 4096]);
            end
`ifdef DKVER1_PEAK_READER_TS_EN
            bad = 0;
            for (int k = 0; k < 4096; k++) begin
                dt = (int'(got[3 * k + 3][15:0]) - int'(got[3 * k][15:0]) + 65536) % 65536;
                if (dt != WRAP_GAP) bad++;
            end
            n_cmp++;
            if (bad != 0 || got[3 * 4096][15:0] !== 16'h0000) begin
                n_fail++; $display("FAIL wrap_ts: bad deltas=%0d last ts=%h expected 0/0000", bad, got[3 * 4096][15:0]);
            end
`endif
        end
        bad = 0;
        if (exp_w.size() != got.size()) bad = 999;
        else foreach (got[k]) if (got[k] !== exp_w[k]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL wrap_stream: mismatched words=%0d expected 0", bad);
        end
    endtask

    task automatic test_random();
        bit to;
        do_clr();
        for (int i = 0; i < 600; i++) begin
            ce = ($urandom_range(3) != 0);
            peakvalid = ($urandom_range(2) == 0);
            rd_if.rd_ready = (i < 300) ? ($urandom_range(3) == 0) : 1'($urandom);
            clr = ($urandom_range(99) == 0);
            rand_peaks();
            @(negedge clk);
            n_cmp++;
            if (rd_if.rd_valid !== m_active || (m_active && rd_if.rd_data !== m_word())) begin
                n_fail++; $display("FAIL rand_out[%0d]: valid=%b data=%h expected %b/%h", i, rd_if.rd_valid, rd_if.rd_data, m_active, m_word());
            end
            n_cmp++;
            if (int'(fifo_count) != m_fifo.size() || int'(overflow_cnt) != m_ovf) begin
                n_fail++; $display("FAIL rand_cnt[%0d]: count=%0d ovf=%0d expected %0d/%0d", i, fifo_count, overflow_cnt, m_fifo.size(), m_ovf);
            end
        end
        clr = 1'b0;
        wait_drain(100, to);
        n_cmp++;
        if (to) begin
            n_fail++; $display("FAIL rand_drain: timed out, expected drain");
        end
    endtask

    task automatic test_reset_mid();
        ce = 1'b1;
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_peaks();
            peakvalid = 1'b1;
            @(negedge clk);
        end
        peakvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rd_if.rd_valid !== 1'b0 || fifo_count !== '0 || overflow_cnt !== 16'h0) begin
            n_fail++; $display("FAIL rstmid: valid=%b count=%0d ovf=%0d expected 0/0/0", rd_if.rd_valid, fifo_count, overflow_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        rand_peaks();
        peakvalid = 1'b1;
        @(negedge clk);
        peakvalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data[31:16] !== 16'hA000) begin
            n_fail++; $display("FAIL rstmid_seq: valid=%b data=%h expected 1/A000xxxx", rd_if.rd_valid, rd_if.rd_data);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_clr();
        test_ce_low();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
